// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : packer_pkg
//  Purpose  : Shared FSM encoding and lane-index width helper for channel_packer.
//  Revision : 1.0  initial release
// ============================================================================
package packer_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_FULL   = 2'd2
    } packer_state_t;

    localparam logic [7:0] c_SEQ_ERR_MAX = 8'hFF;

    // A single-lane configuration still needs a 1-bit channel index.
    function automatic int lane_width(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lane_sequencer
//  Purpose  : Tracks the expected lane, flags out-of-order samples and counts them.
//  Revision : 1.0  initial release
// ============================================================================
module lane_sequencer
    import packer_pkg::*;
#(
    parameter int NUM_CHANNELS = 4
)(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_accept,
    input  logic [lane_width(NUM_CHANNELS)-1:0] i_ch,
    output logic                                o_store,
    output logic                                o_last,
    output logic [7:0]                          o_err_cnt
);

    localparam int                LANE_W      = lane_width(NUM_CHANNELS);
    localparam logic [LANE_W-1:0] c_LANE_ZERO = '0;
    localparam logic [LANE_W-1:0] c_LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0] c_LANE_LAST = LANE_W'(NUM_CHANNELS - 1);

    logic [LANE_W-1:0] r_expected;
    logic [7:0]        r_err_cnt;
    logic              w_match;
    logic              w_mismatch;
    logic              w_restart;

    assign w_match    = i_accept && (i_ch == r_expected);
    assign w_mismatch = i_accept && (i_ch != r_expected);
    // An unexpected lane 0 is taken as the start of a new frame.
    assign w_restart  = w_mismatch && (i_ch == c_LANE_ZERO);

    assign o_store    = w_match || w_restart;
    assign o_last     = w_match && (r_expected == c_LANE_LAST);
    assign o_err_cnt  = r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_expected <= c_LANE_ZERO;
            r_err_cnt  <= '0;
        end else begin
            if (o_last) begin
                r_expected <= c_LANE_ZERO;
            end else if (w_match) begin
                r_expected <= r_expected + c_LANE_ONE;
            end else if (w_restart) begin
                r_expected <= c_LANE_ONE;
            end else if (w_mismatch) begin
                r_expected <= c_LANE_ZERO;
            end

            if (w_mismatch && (r_err_cnt != c_SEQ_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/channel_packer.sv
`default_nettype none
// ============================================================================
//  Module   : channel_packer
//  Purpose  : Packs per-channel samples into wide words and writes them to a RAM.
//  Revision : 1.0  initial release
// ============================================================================
module channel_packer
    import packer_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 1,
    parameter bit DEBUG        = 1'b0
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                sample_in,
    input  logic [lane_width(NUM_CHANNELS)-1:0]  sample_ch,
    input  logic                                 sample_valid,
    output logic                                 sample_ready,
    input  logic                                 drain,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   wide_data_out,
    output logic                                 write_en,
    output logic [ADDR_WIDTH-1:0]                addr,
    output logic                                 buf_full,
    output logic [7:0]                           seq_err_cnt
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);

    packer_state_t                             r_state;
    packer_state_t                             w_next_state;
    logic                                      r_armed;
    logic [ADDR_WIDTH-1:0]                     r_addr;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   r_lanes;
    logic                                      w_accept;
    logic                                      w_store;
    logic                                      w_last;
    logic                                      w_ready;
    logic                                      w_write_en;
    logic                                      w_buf_full;

    assign w_accept      = sample_valid && w_ready;
    assign sample_ready  = w_ready;
    assign write_en      = w_write_en;
    assign buf_full      = w_buf_full;
    assign addr          = r_addr;
    assign wide_data_out = r_lanes;

    lane_sequencer #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_lane_sequencer (
        .clk       (clk),
        .rst       (rst),
        .i_accept  (w_accept),
        .i_ch      (sample_ch),
        .o_store   (w_store),
        .o_last    (w_last),
        .o_err_cnt (seq_err_cnt)
    );

    // r_armed keeps sample_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FILL;
            r_armed <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            r_armed <= 1'b1;
            if ((r_state == ST_COMMIT) && !(&r_addr)) begin
                r_addr <= r_addr + c_ADDR_ONE;
            end else if ((r_state == ST_FULL) && drain) begin
                r_addr <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lanes <= '0;
        end else if (w_store) begin
            r_lanes[sample_ch] <= sample_in;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_write_en   = 1'b0;
        w_buf_full   = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_ready = r_armed;
                if (w_last) begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_write_en   = 1'b1;
                w_next_state = (&r_addr) ? ST_FULL : ST_FILL;
            end
            ST_FULL: begin
                w_buf_full = 1'b1;
                if (drain) begin
                    w_next_state = ST_FILL;
                end
            end
            default: begin
                w_next_state = ST_FILL;
            end
        endcase
    end

    generate
        if (DEBUG) begin : g_debug
            always_comb begin
                if (rst) begin
                    assert (!(w_write_en && w_buf_full));
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire
